// File: rtl/bpu_btb_pkg.sv
// Shared types for the branch target buffer and its return-address stack.
package bpu_btb_pkg;

  typedef enum logic [1:0] {
    KIND_BR   = 2'd0,
    KIND_JMP  = 2'd1,
    KIND_CALL = 2'd2,
    KIND_RET  = 2'd3
  } btb_kind_e;

  // Per-entry control fields. Tag and target widths depend on module
  // parameters, so those live in parallel arrays indexed the same way.
  typedef struct packed {
    logic      valid;
    btb_kind_e kind;
    logic [1:0] ctr;
  } btb_entry_t;

  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  // Two-bit saturating counter step.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) nxt = ctr + 2'd1;
    else if (!taken && ctr != 2'b00) nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bpu_ras.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; squash empties the stack and takes priority over push/pop.
module bpu_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            squash,
  input  logic [XLEN-1:0] push_addr,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [XLEN-1:0]  stack_q [DEPTH];
  logic [XLEN-1:0]  stack_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx;

  assign top_idx = ptr_q - 1'b1;
  assign top     = stack_q[top_idx];
  assign empty   = (cnt_q == '0);

  // Next stack state: squash first, then push, then pop (pop ignored when empty).
  always_comb begin
    stack_d = stack_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (squash) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (push) begin
      stack_d[ptr_q] = push_addr;
      ptr_d          = ptr_q + 1'b1;
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Stack registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      stack_q <= stack_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/bpu_btb.sv
// Direct-mapped, flop-based branch target buffer with 2-bit direction
// counters and a return-address stack for call/return prediction.
module bpu_btb
  import bpu_btb_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 64,
  parameter int TAG_W     = 10,
  parameter int RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lk_valid,
  input  logic [XLEN-1:0] lk_pc,
  output logic            lk_hit,
  output logic            lk_taken,
  output logic [XLEN-1:0] lk_target,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [1:0]      upd_kind,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            squash
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = TAG_LO + TAG_W - 1;

  btb_entry_t       meta_q [ENTRIES];
  btb_entry_t       meta_d [ENTRIES];
  logic [TAG_W-1:0] tag_q  [ENTRIES];
  logic [TAG_W-1:0] tag_d  [ENTRIES];
  logic [XLEN-1:0]  tgt_q  [ENTRIES];
  logic [XLEN-1:0]  tgt_d  [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  btb_entry_t       lk_ent;
  btb_kind_e        upd_kind_e;
  logic             upd_hit;
  logic [XLEN-1:0]  pc_plus4;
  logic             ras_push, ras_pop, ras_empty;
  logic [XLEN-1:0]  ras_top;
  logic             unused_pc_bits;

  assign lk_idx     = lk_pc[IDX_W+1:2];
  assign lk_tag     = lk_pc[TAG_HI:TAG_LO];
  assign upd_idx    = upd_pc[IDX_W+1:2];
  assign upd_tag    = upd_pc[TAG_HI:TAG_LO];
  assign lk_ent     = meta_q[lk_idx];
  assign lk_hit     = lk_ent.valid && (tag_q[lk_idx] == lk_tag);
  assign upd_hit    = meta_q[upd_idx].valid && (tag_q[upd_idx] == upd_tag);
  assign upd_kind_e = btb_kind_e'(upd_kind);
  assign pc_plus4   = lk_pc + XLEN'(4);

  // Byte offset and bits above the tag do not take part in matching.
  assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0], lk_pc[XLEN-1:TAG_HI+1], upd_pc[XLEN-1:TAG_HI+1]};

  // Zero-latency prediction from pre-update table contents, plus RAS control.
  always_comb begin
    lk_taken  = 1'b0;
    lk_target = pc_plus4;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    if (lk_hit) begin
      case (lk_ent.kind)
        KIND_BR: begin
          if (lk_ent.ctr[1]) begin
            lk_taken  = 1'b1;
            lk_target = tgt_q[lk_idx];
          end
        end
        KIND_JMP: begin
          lk_taken  = 1'b1;
          lk_target = tgt_q[lk_idx];
        end
        KIND_CALL: begin
          lk_taken  = 1'b1;
          lk_target = tgt_q[lk_idx];
          ras_push  = lk_valid;
        end
        KIND_RET: begin
          if (!ras_empty) begin
            lk_taken  = 1'b1;
            lk_target = ras_top;
            ras_pop   = lk_valid;
          end
        end
        default: ;
      endcase
    end
  end

  // Table update: train on tag hit, allocate on miss unless a not-taken branch.
  always_comb begin
    meta_d = meta_q;
    tag_d  = tag_q;
    tgt_d  = tgt_q;
    if (upd_en) begin
      if (upd_hit) begin
        if (upd_kind_e == KIND_BR)
          meta_d[upd_idx].ctr = ctr_step(meta_q[upd_idx].ctr, upd_taken);
        meta_d[upd_idx].kind = upd_kind_e;
        if (upd_taken) tgt_d[upd_idx] = upd_target;
      end else if (upd_taken || upd_kind_e != KIND_BR) begin
        meta_d[upd_idx] = '{valid: 1'b1, kind: upd_kind_e, ctr: CTR_ALLOC};
        tag_d[upd_idx]  = upd_tag;
        tgt_d[upd_idx]  = upd_target;
      end
    end
  end

  // Table registers; reset invalidates every entry immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        meta_q[i] <= '{valid: 1'b0, kind: KIND_BR, ctr: CTR_RESET};
        tag_q[i]  <= '0;
        tgt_q[i]  <= '0;
      end
    end else begin
      meta_q <= meta_d;
      tag_q  <= tag_d;
      tgt_q  <= tgt_d;
    end
  end

  bpu_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .squash    (squash),
    .push_addr (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty)
  );

endmodule

// File: tb/tb_bpu_btb.sv
// Directed bench for bpu_btb with default parameters (64 entries, RAS depth 8).
module tb_bpu_btb;

  logic        clk = 1'b0;
  logic        reset;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        lk_hit, lk_taken;
  logic [31:0] lk_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic [1:0]  upd_kind;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        squash;

  int n_cmp = 0;
  int n_err = 0;

  bpu_btb dut (
    .clk        (clk),
    .reset      (reset),
    .lk_valid   (lk_valid),
    .lk_pc      (lk_pc),
    .lk_hit     (lk_hit),
    .lk_taken   (lk_taken),
    .lk_target  (lk_target),
    .upd_en     (upd_en),
    .upd_pc     (upd_pc),
    .upd_kind   (upd_kind),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .squash     (squash)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a lookup and check the combinational prediction (no clock advance).
  task automatic look(input logic [31:0] pc, input logic v, input logic eh, input logic et,
                      input logic [31:0] etgt, input string tag);
    lk_pc    = pc;
    lk_valid = v;
    #1;
    chk({tag, "_hit"},    {31'b0, lk_hit},   {31'b0, eh});
    chk({tag, "_taken"},  {31'b0, lk_taken}, {31'b0, et});
    chk({tag, "_target"}, lk_target,         etgt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    lk_valid = 1'b0;
    squash   = 1'b0;
    upd_en   = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [1:0] kind, input logic tk,
                     input logic [31:0] tgt);
    upd_en     = 1'b1;
    upd_pc     = pc;
    upd_kind   = kind;
    upd_taken  = tk;
    upd_target = tgt;
    tick();
  endtask

  initial begin
    reset = 1'b1; lk_valid = 1'b0; lk_pc = '0; upd_en = 1'b0; upd_pc = '0;
    upd_kind = '0; upd_taken = 1'b0; upd_target = '0; squash = 1'b0;

    #3;
    look(32'h100, 1'b0, 1'b0, 1'b0, 32'h104, "rst_during");
    #18 reset = 1'b0;
    tick();
    look(32'h100, 1'b0, 1'b0, 1'b0, 32'h104, "rst_after");

    // Branch learning; lookup in the update cycle still sees the old table
    upd_en = 1'b1; upd_pc = 32'h100; upd_kind = 2'd0; upd_taken = 1'b1; upd_target = 32'h80;
    look(32'h100, 1'b0, 1'b0, 1'b0, 32'h104, "upd_same_cycle");
    tick();
    look(32'h100, 1'b0, 1'b1, 1'b1, 32'h80, "br_learn");

    // Counter hysteresis and saturation
    upd(32'h100, 2'd0, 1'b0, 32'h80);
    upd(32'h100, 2'd0, 1'b0, 32'h80);
    look(32'h100, 1'b0, 1'b1, 1'b0, 32'h104, "br_ctr0");
    upd(32'h100, 2'd0, 1'b1, 32'h80);
    look(32'h100, 1'b0, 1'b1, 1'b0, 32'h104, "br_ctr1");
    upd(32'h100, 2'd0, 1'b1, 32'h80);
    look(32'h100, 1'b0, 1'b1, 1'b1, 32'h80, "br_ctr2");
    upd(32'h100, 2'd0, 1'b1, 32'h80);
    upd(32'h100, 2'd0, 1'b1, 32'h80);
    upd(32'h100, 2'd0, 1'b0, 32'h80);
    look(32'h100, 1'b0, 1'b1, 1'b1, 32'h80, "br_sat3");

    // Call/return; 0x200 shares index 0 with 0x100 and evicts it
    upd(32'h200, 2'd2, 1'b1, 32'h400);
    upd(32'h440, 2'd3, 1'b1, 32'h0);
    look(32'h100, 1'b0, 1'b0, 1'b0, 32'h104, "evicted");
    look(32'h440, 1'b0, 1'b1, 1'b0, 32'h444, "ret_empty");
    look(32'h200, 1'b1, 1'b1, 1'b1, 32'h400, "call");
    tick();
    look(32'h440, 1'b1, 1'b1, 1'b1, 32'h204, "ret_pop");
    tick();
    look(32'h440, 1'b0, 1'b1, 1'b0, 32'h444, "ret_after_pop");

    // RAS overflow: 9 pushes into 8 slots, oldest lost
    for (int k = 0; k < 9; k++) upd(32'h1000 + 32'(4*k), 2'd2, 1'b1, 32'h3000);
    for (int k = 0; k < 9; k++) begin
      look(32'h1000 + 32'(4*k), 1'b1, 1'b1, 1'b1, 32'h3000, "ovf_call");
      tick();
    end
    for (int j = 0; j < 8; j++) begin
      look(32'h440, 1'b1, 1'b1, 1'b1, 32'h1024 - 32'(4*j), "ovf_ret");
      tick();
    end
    look(32'h440, 1'b1, 1'b1, 1'b0, 32'h444, "ovf_empty");
    tick();
    look(32'h1000, 1'b1, 1'b1, 1'b1, 32'h3000, "call_after_under");
    tick();
    look(32'h440, 1'b1, 1'b1, 1'b1, 32'h1004, "ret_after_under");
    tick();

    // Aliasing and not-taken miss
    upd(32'h100, 2'd0, 1'b1, 32'h80);
    look(32'h100, 1'b0, 1'b1, 1'b1, 32'h80, "alias_a");
    upd(32'h200, 2'd1, 1'b1, 32'h900);
    look(32'h100, 1'b0, 1'b0, 1'b0, 32'h104, "alias_miss");
    look(32'h200, 1'b0, 1'b1, 1'b1, 32'h900, "jmp_hit");
    upd(32'h300, 2'd0, 1'b0, 32'h50);
    look(32'h300, 1'b0, 1'b0, 1'b0, 32'h304, "nt_noalloc");
    look(32'h200, 1'b0, 1'b1, 1'b1, 32'h900, "nt_keep");

    // Squash beats a coincident push and drops earlier contents
    look(32'h1004, 1'b1, 1'b1, 1'b1, 32'h3000, "sq_pre");
    tick();
    squash = 1'b1;
    look(32'h1004, 1'b1, 1'b1, 1'b1, 32'h3000, "sq_push");
    tick();
    look(32'h440, 1'b0, 1'b1, 1'b0, 32'h444, "sq_empty");

    // Asynchronous reset mid-cycle
    look(32'h1004, 1'b0, 1'b1, 1'b1, 32'h3000, "pre_reset");
    reset = 1'b1;
    look(32'h1004, 1'b0, 1'b0, 1'b0, 32'h1008, "async_rst");
    look(32'h440, 1'b0, 1'b0, 1'b0, 32'h444, "async_rst_ret");
    reset = 1'b0;
    tick();
    look(32'h200, 1'b0, 1'b0, 1'b0, 32'h204, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
